// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 32x32 register file.
// Two writeback requesters (A: main WB stage, B: long-latency unit) share the
// single write port through a one-cycle registered write stage. A 32-bit
// scoreboard tracks destinations reserved at issue so the control FSM can
// detect read hazards before it reads the register file.
module regfile_wr_arbiter #(
   parameter bit RR_EN       = 1'b1,  // 1: alternate on contention, 0: A always wins
   parameter bit ZERO_REG_RO = 1'b1   // 1: register 0 is never written or reserved
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [4:0]  a_reg,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_reg,
   input  logic [31:0] b_data,
   input  logic        rsv_valid,
   input  logic [4:0]  rsv_reg,
   input  logic [4:0]  rd_reg1,
   input  logic [4:0]  rd_reg2,
   output logic        hazard,
   output logic [31:0] busy_mask,
   output logic        RegWr,
   output logic [4:0]  W_Reg,
   output logic [31:0] W_data
);

   // last_grant: 1 means B was granted last, so A wins the next tie
   logic        last_grant_q, last_grant_d;
   logic        regwr_q, regwr_d;
   logic [4:0]  w_reg_q, w_reg_d;
   logic [31:0] w_data_q, w_data_d;
   logic [31:0] busy_q, busy_d;

   logic        a_win, b_win, xfer, drop_zero;
   logic [4:0]  sel_reg;
   logic [31:0] sel_data;

   // Grant selection; readies are forced low while reset is held
   always_comb begin
      a_win   = a_valid & (~b_valid | ~RR_EN | last_grant_q);
      b_win   = b_valid & ~a_win;
      a_ready = a_win & ~RST;
      b_ready = b_win & ~RST;
   end

   // Next-state for the write stage and grant history
   always_comb begin
      xfer         = a_ready | b_ready;
      sel_reg      = a_ready ? a_reg  : b_reg;
      sel_data     = a_ready ? a_data : b_data;
      drop_zero    = ZERO_REG_RO && (sel_reg == 5'd0);
      regwr_d      = xfer & ~drop_zero;
      w_reg_d      = xfer ? sel_reg  : w_reg_q;
      w_data_d     = xfer ? sel_data : w_data_q;
      last_grant_d = xfer ? b_ready  : last_grant_q;
   end

   // Scoreboard: clear on commit, then set on reservation so a same-edge set wins
   always_comb begin
      busy_d = busy_q;
      if (regwr_q)
         busy_d[w_reg_q] = 1'b0;
      if (rsv_valid && !(ZERO_REG_RO && (rsv_reg == 5'd0)))
         busy_d[rsv_reg] = 1'b1;
   end

   // State registers; reset drops any accepted-but-uncommitted write
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         last_grant_q <= 1'b1;
         regwr_q      <= 1'b0;
         w_reg_q      <= 5'd0;
         w_data_q     <= 32'd0;
         busy_q       <= 32'd0;
      end else begin
         last_grant_q <= last_grant_d;
         regwr_q      <= regwr_d;
         w_reg_q      <= w_reg_d;
         w_data_q     <= w_data_d;
         busy_q       <= busy_d;
      end
   end

   // Hazard lookup; no forwarding, a reserved register stays hazardous until its commit edge
   always_comb begin
      hazard = (busy_q[rd_reg1] & ~(ZERO_REG_RO && (rd_reg1 == 5'd0))) |
               (busy_q[rd_reg2] & ~(ZERO_REG_RO && (rd_reg2 == 5'd0)));
   end

   assign RegWr     = regwr_q;
   assign W_Reg     = w_reg_q;
   assign W_data    = w_data_q;
   assign busy_mask = busy_q;

endmodule
